// File: rtl/obi_read_master.sv
// OBI block-read initiator: issues word reads for one (addr, len) command and
// streams the responses out of a small FIFO, tagging the final word.
module obi_read_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // Every port pair below (cmd, OBI req/gnt, data stream) transfers exactly on
  // the cycle where valid/req and ready/gnt are both high; a raised
  // valid/req is held stable, with its payload, until that cycle.
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [31:0]      cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic             req_o,
  input  logic             gnt_i,
  output logic [31:0]      addr_o,
  output logic             we_o,
  output logic [3:0]       be_o,
  output logic [31:0]      wdata_o,
  input  logic             rvalid_i,
  input  logic [31:0]      rdata_i,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic [31:0]      data_o,
  output logic             data_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] rem_q, len_q, resp_cnt_q;
  logic [CW-1:0]    out_q, cnt_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             err_q, done_len0_q;
  logic [32:0]      mem [FIFO_DEPTH];

  logic cmd_fire, credit_ok, gnt_fire, push, pop, drain_done, last_bit;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_addr_i[1:0];

  assign cmd_fire   = cmd_valid_i && (state_q == IDLE);
  // Credit counts reads in flight plus words buffered, so a granted read
  // always has a FIFO slot waiting for its response.
  assign credit_ok  = ({1'b0, out_q} + {1'b0, cnt_q}) < (CW+1)'(FIFO_DEPTH);
  assign req_o      = (state_q == ISSUE) && (rem_q != '0) && credit_ok;
  assign gnt_fire   = req_o && gnt_i;
  assign push       = rvalid_i && (out_q != '0);
  assign last_bit   = ((resp_cnt_q + LEN_W'(1)) == len_q);
  assign pop        = data_valid_o && data_ready_i;
  assign drain_done = (state_q == DRAIN) && (out_q == '0) && (cnt_q == '0);

  assign cmd_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = drain_done || done_len0_q;
  assign err_o        = err_q;
  assign addr_o       = addr_q;
  assign we_o         = 1'b0;
  assign be_o         = 4'hF;
  assign wdata_o      = '0;
  assign data_valid_o = (cnt_q != '0);
  assign data_o       = data_valid_o ? mem[rd_ptr_q][31:0] : '0;
  assign data_last_o  = data_valid_o && mem[rd_ptr_q][32];
  assign dbg_state_o  = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid_i && (cmd_len_i != '0)) state_d = ISSUE;
      ISSUE:   if (gnt_fire && (rem_q == LEN_W'(1))) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      len_q       <= '0;
      resp_cnt_q  <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
      done_len0_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_len0_q <= cmd_fire && (cmd_len_i == '0);
      if (cmd_fire) begin
        addr_q     <= {cmd_addr_i[31:2], 2'b00};
        rem_q      <= cmd_len_i;
        len_q      <= cmd_len_i;
        resp_cnt_q <= '0;
        err_q      <= 1'b0;
      end else begin
        if (gnt_fire) begin
          addr_q <= addr_q + 32'd4;
          rem_q  <= rem_q - LEN_W'(1);
        end
        // A response with nothing outstanding is dropped but remembered.
        if (rvalid_i && (out_q == '0)) err_q <= 1'b1;
        if (push) resp_cnt_q <= resp_cnt_q + LEN_W'(1);
      end
      case ({gnt_fire, push})
        2'b10:   out_q <= out_q + CW'(1);
        2'b01:   out_q <= out_q - CW'(1);
        default: out_q <= out_q;
      endcase
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= {last_bit, rdata_i};
  end

endmodule

// File: tb/tb_obi_read_master.sv
// Bench for obi_read_master: OBI responder model, random stream consumer and
// a scoreboard fed from the command (address, length) alone.
module tb_obi_read_master;

  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = 16;

  logic             clk_i, rst_ni;
  logic             cmd_valid_i, cmd_ready_o;
  logic [31:0]      cmd_addr_i;
  logic [LEN_W-1:0] cmd_len_i;
  logic             req_o, gnt_i, we_o;
  logic [31:0]      addr_o, wdata_o, rdata_i, data_o;
  logic [3:0]       be_o;
  logic             rvalid_i, data_valid_o, data_ready_i, data_last_o;
  logic             busy_o, done_o, err_o;
  logic [1:0]       dbg_state_o;

  obi_read_master #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o),
    .be_o(be_o), .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .data_o(data_o), .data_last_o(data_last_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] rsp_q[$];
  int          rsp_t_q[$];
  int n_cmp = 0, n_err = 0;
  int n_gnt, n_pop, done_exp_cyc = -1, acc_cyc;
  int first_req_cyc, first_val_cyc, first_pop_cyc, last_pop_cyc;
  bit done_seen, mon_en = 0, spur_req = 0, prev_stall = 0;
  logic [31:0] prev_addr, data_xor = '0;
  int stall_n = 0, stall_cnt = 0, gnt_pct = 100, rdy_pct = 100, extra_max = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready_o, 1);
    check({tag, "_req"}, req_o, 0);
    check({tag, "_valid"}, data_valid_o, 0);
    check({tag, "_last"}, data_last_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_addr"}, addr_o, 0);
    check({tag, "_data"}, data_o, 0);
  endtask

  // ---------------- responder, consumer and monitor ----------------
  initial forever begin
    @(negedge clk_i);
    if (!rst_ni || !mon_en) begin
      gnt_i = 1'b0; rvalid_i = 1'b0; data_ready_i = 1'b0;
      prev_stall = 0; stall_cnt = 0;
      continue;
    end
    rvalid_i = 1'b0;
    if (spur_req) begin
      rvalid_i = 1'b1; rdata_i = $urandom; spur_req = 0;
    end else if (rsp_q.size() > 0 && rsp_t_q[0] <= cyc) begin
      rvalid_i = 1'b1; rdata_i = rsp_q.pop_front(); void'(rsp_t_q.pop_front());
    end
    gnt_i = 1'b0;
    if (req_o) begin
      if (stall_n >= 0) begin
        if (stall_cnt < stall_n) stall_cnt++;
        else begin gnt_i = 1'b1; stall_cnt = 0; end
      end else gnt_i = ($urandom_range(99) < gnt_pct);
    end
    if (gnt_i) begin
      rsp_q.push_back(addr_o ^ data_xor);
      rsp_t_q.push_back(cyc + 1 + $urandom_range(extra_max));
    end
    data_ready_i = ($urandom_range(99) < rdy_pct);

    if (prev_stall) begin
      check("req_hold", req_o, 1);
      check("addr_hold", addr_o, prev_addr);
    end
    prev_stall = req_o && !gnt_i;
    prev_addr  = addr_o;
    if (req_o && first_req_cyc < 0) first_req_cyc = cyc;
    if (data_valid_o && first_val_cyc < 0) first_val_cyc = cyc;
    if (req_o && gnt_i) begin
      n_gnt++;
      if (exp_addr_q.size() == 0) check("extra_grant", 1, 0);
      else check("grant_addr", addr_o, exp_addr_q.pop_front());
      check("credit", 64'((n_gnt - n_pop) <= FIFO_DEPTH), 1);
    end
    if (data_valid_o && data_ready_i) begin
      n_pop++;
      if (exp_q.size() == 0) check("extra_pop", 1, 0);
      else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("data", data_o, e[31:0]);
        check("data_last", data_last_o, e[32]);
        if (e[32]) done_exp_cyc = cyc + 1;
      end
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    check("done_pulse", done_o, 64'(cyc == done_exp_cyc));
    if (done_o) done_seen = 1;
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [31:0] addr, input int len);
    logic [31:0] wa;
    @(negedge clk_i); #2;
    check("cmd_ready_idle", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_addr_i = addr; cmd_len_i = LEN_W'(len);
    acc_cyc = cyc; n_gnt = 0; n_pop = 0; done_seen = 0;
    first_req_cyc = -1; first_val_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
    wa = {addr[31:2], 2'b00};
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(wa + 32'(4 * i));
      exp_q.push_back({(i == len - 1), (wa + 32'(4 * i)) ^ data_xor});
    end
    if (len == 0) done_exp_cyc = cyc + 1;
    @(negedge clk_i); #2;
    cmd_valid_i = 1'b0;
    check("busy_after_accept", busy_o, 64'(len != 0));
    check("cmd_ready_after_accept", cmd_ready_o, 64'(len == 0));
    check("err_cleared", err_o, 0);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done_seen && k < budget) begin
      @(negedge clk_i); #2;
      k++;
    end
    check("done_timeout", done_seen, 1);
    check("exp_drained", exp_q.size(), 0);
    @(negedge clk_i); #2;
    check("idle_busy", busy_o, 0);
    check("idle_cmd_ready", cmd_ready_o, 1);
    check("idle_err", err_o, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; data_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #2;
    check_reset_vals("reset");
    check("tie_we", we_o, 0);
    check("tie_be", be_o, 4'hF);
    check("tie_wdata", wdata_o, 0);
    rst_ni = 1'b1; mon_en = 1;

    // basic zero-wait read, addr-as-data
    stall_n = 0; extra_max = 0; rdy_pct = 100; data_xor = '0;
    send_cmd(32'h8000_0010, 4);
    wait_done(100);
    check("basic_grants", n_gnt, 4);
    check("basic_req_latency", first_req_cyc - acc_cyc, 1);
    check("basic_valid_latency", first_val_cyc - acc_cyc, 3);
    check("basic_back_to_back", last_pop_cyc - first_pop_cyc, 3);

    // grant stalls
    stall_n = 3; data_xor = $urandom;
    send_cmd($urandom, 3);
    wait_done(200);
    check("stall_grants", n_gnt, 3);

    // backpressure
    stall_n = 0; rdy_pct = 0; data_xor = $urandom;
    send_cmd(32'h0000_1000, 10);
    repeat (20) @(negedge clk_i);
    #2;
    check("bp_grants", n_gnt, FIFO_DEPTH);
    check("bp_req_low", req_o, 0);
    rdy_pct = 100;
    wait_done(200);
    check("bp_total_pops", n_pop, 10);

    // zero-length command
    send_cmd(32'h2000_0000, 0);
    check("len0_no_req", n_gnt, 0);
    wait_done(20);

    // spurious response in IDLE
    @(negedge clk_i); #2;
    spur_req = 1;
    repeat (2) @(negedge clk_i);
    #2;
    check("spur_err", err_o, 1);
    check("spur_fifo_empty", data_valid_o, 0);
    send_cmd(32'h0000_0040, 1);
    wait_done(50);

    // reset mid-burst
    stall_n = 0; rdy_pct = 100; data_xor = $urandom;
    send_cmd(32'h0100_0000, 8);
    for (int k = 0; k < 100 && n_gnt < 3; k++) begin
      @(negedge clk_i); #2;
    end
    check("rst_reached_3_grants", n_gnt, 3);
    @(negedge clk_i); #2;
    rst_ni = 1'b0;
    exp_q.delete(); exp_addr_q.delete(); rsp_q.delete(); rsp_t_q.delete();
    done_exp_cyc = -1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk_i); #2;
    rst_ni = 1'b1;
    #1;
    check_reset_vals("midrst_release");
    spur_req = 1;
    repeat (2) @(negedge clk_i);
    #2;
    check("late_rsp_err", err_o, 1);
    send_cmd(32'h0100_0100, 2);
    wait_done(50);

    // randomized commands
    for (int t = 0; t < 12; t++) begin
      logic [31:0] a;
      int len;
      a = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      len = $urandom_range(24, 1);
      if ($urandom_range(1) == 1) begin
        stall_n = -1; gnt_pct = $urandom_range(100, 30);
      end else stall_n = $urandom_range(2);
      rdy_pct = $urandom_range(100, 20);
      extra_max = $urandom_range(3);
      data_xor = $urandom;
      send_cmd(a, len);
      wait_done(300 + 60 * len);
      check("rand_grants", n_gnt, len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
